// File: rtl/delay_fx_core.sv
// Delay-line effects engine: one 12-bit sample in, one processed sample out, with
// optional reverb feedback written into a circular line and an LFO-swept chorus tap.
module delay_fx_core #(
   parameter int ADDR_W       = 16,
   parameter int CHORUS_BASE  = 1000,
   parameter int CHORUS_DEPTH = 500,
   parameter int LFO_DIV      = 20,
   parameter int REVERB_DLY   = 5000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sample_valid,
   input  logic [11:0]       sample_in,
   input  logic              chorus_on,
   input  logic              reverb_on,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   output logic [11:0]       sample_out,
   output logic              out_valid,
   output logic              overrun
);

   typedef enum logic [2:0] {IDLE, RD_C, RD_R, CAP, WR, OUT} state_t;

   localparam logic [ADDR_W-1:0] CB       = ADDR_W'(CHORUS_BASE);
   localparam logic [ADDR_W-1:0] RDLY     = ADDR_W'(REVERB_DLY);
   localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(CHORUS_DEPTH);
   localparam logic [ADDR_W-1:0] FILL_MAX = '1;
   localparam int                DIV_W    = (LFO_DIV > 1) ? $clog2(LFO_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(LFO_DIV - 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] fill;
   logic [ADDR_W-1:0] lfo;
   logic              lfo_up;
   logic [DIV_W-1:0]  div_cnt;

   logic [11:0]       x_p0;
   logic [11:0]       dc_p1;
   logic [11:0]       dr_p2;
   logic [11:0]       w_c;
   logic [11:0]       y_c;
   logic [ADDR_W-1:0] c_dly;
   logic              unused_rdata;

   // Halved 13-bit sum; the dropped LSB truncates toward zero.
   function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[12:1];
   endfunction

   // Taps reaching behind the first sample since reset read as midscale.
   function automatic logic [11:0] prime(input logic [ADDR_W-1:0] filled,
                                         input logic [ADDR_W-1:0] dly,
                                         input logic [11:0]       rd);
      return (filled < dly) ? 12'h800 : rd;
   endfunction

   assign unused_rdata = ^mem_rdata[15:12];
   assign c_dly        = CB + lfo;
   assign w_c          = reverb_on ? avg12(x_p0, dr_p2) : x_p0;
   assign y_c          = chorus_on ? avg12(w_c, dc_p1) : w_c;
   assign mem_we       = (state == WR);
   assign mem_wdata    = {4'b0, w_c};

   always_comb begin
      mem_addr = wr_ptr;
      case (state)
         RD_C:    mem_addr = wr_ptr - c_dly;
         RD_R:    mem_addr = wr_ptr - RDLY;
         default: mem_addr = wr_ptr;
      endcase
   end

   // p0: input latch, p1: chorus tap, p2: reverb tap
   always_ff @(posedge clk) begin
      if (state == IDLE && sample_valid) x_p0 <= sample_in;
      if (state == RD_R) dc_p1 <= prime(fill, c_dly, mem_rdata[11:0]);
      if (state == CAP)  dr_p2 <= prime(fill, RDLY, mem_rdata[11:0]);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         sample_out <= 12'h000;
         overrun    <= 1'b0;
         wr_ptr     <= '0;
         fill       <= '0;
         lfo        <= '0;
         lfo_up     <= 1'b1;
         div_cnt    <= '0;
      end else begin
         out_valid <= 1'b0;
         if (sample_valid && state != IDLE) overrun <= 1'b1;
         case (state)
            IDLE: if (sample_valid) state <= RD_C;
            RD_C: state <= RD_R;
            RD_R: state <= CAP;
            CAP:  state <= WR;
            WR: begin
               state      <= OUT;
               out_valid  <= 1'b1;
               sample_out <= y_c;
            end
            OUT: begin
               state  <= IDLE;
               wr_ptr <= wr_ptr + ADDR_W'(1);
               if (fill != FILL_MAX) fill <= fill + ADDR_W'(1);
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  // Triangle turns around on the end value itself, never dwelling there.
                  if (DEPTH != '0) begin
                     if (lfo_up) begin
                        lfo <= lfo + ADDR_W'(1);
                        if (lfo + ADDR_W'(1) == DEPTH) lfo_up <= 1'b0;
                     end else begin
                        lfo <= lfo - ADDR_W'(1);
                        if (lfo == ADDR_W'(1)) lfo_up <= 1'b1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_fx_core.sv
// Bench for delay_fx_core: two differently sized instances share stimulus and are
// compared against a sample-history reference model.
module tb_delay_fx_core;

   localparam int CA[2]    = '{4, 5};
   localparam int CBASE[2] = '{1, 3};
   localparam int CDEP[2]  = '{2, 3};
   localparam int CDIV[2]  = '{1, 2};
   localparam int CRDLY[2] = '{4, 7};

   logic        clk, reset, sample_valid, chorus_on, reverb_on;
   logic [11:0] sample_in;
   logic [3:0]  addr_a;
   logic [4:0]  addr_b;
   logic        we_a, we_b, ov_a, ov_b, orun_a, orun_b;
   logic [15:0] wdata_a, wdata_b, rdata_a, rdata_b;
   logic [11:0] out_a, out_b;
   logic [11:0] mem_a [0:15];
   logic [11:0] mem_b [0:31];

   int n_pass, n_total;
   int cnt [2];
   logic [11:0] hist [2][0:1023];
   int e_caddr [2], e_raddr [2], e_waddr [2], e_w [2], e_y [2];
   logic [31:0] ob_caddr [2], ob_raddr [2], ob_we [2], ob_waddr [2], ob_wdata [2];
   logic [31:0] ob_ovl [2], ob_out [2], ob_orun [2];
   bit ob_quiet [2];

   delay_fx_core #(.ADDR_W(4), .CHORUS_BASE(1), .CHORUS_DEPTH(2), .LFO_DIV(1), .REVERB_DLY(4)) dut_a (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
      .chorus_on(chorus_on), .reverb_on(reverb_on), .mem_addr(addr_a), .mem_we(we_a),
      .mem_wdata(wdata_a), .mem_rdata(rdata_a), .sample_out(out_a), .out_valid(ov_a),
      .overrun(orun_a));

   delay_fx_core #(.ADDR_W(5), .CHORUS_BASE(3), .CHORUS_DEPTH(3), .LFO_DIV(2), .REVERB_DLY(7)) dut_b (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
      .chorus_on(chorus_on), .reverb_on(reverb_on), .mem_addr(addr_b), .mem_we(we_b),
      .mem_wdata(wdata_b), .mem_rdata(rdata_b), .sample_out(out_b), .out_valid(ov_b),
      .overrun(orun_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read memories; the upper nibble is junk the core must ignore.
   always @(posedge clk) begin
      if (we_a) mem_a[addr_a] <= wdata_a[11:0];
      rdata_a <= {4'hA, mem_a[addr_a]};
      if (we_b) mem_b[addr_b] <= wdata_b[11:0];
      rdata_b <= {4'h5, mem_b[addr_b]};
   end

   function automatic void model_reset();
      cnt[0] = 0;
      cnt[1] = 0;
   endfunction

   // Sample n: written to n mod 2**A; a tap of delay d sees sample n-d, or midscale if n < d.
   function automatic void model_step(input int i, input int x, input bit ch, input bit rv);
      int n, k, p, lfo, cd, mask, dc, dr, w, y;
      n    = cnt[i];
      mask = (1 << CA[i]) - 1;
      k    = n / CDIV[i];
      if (CDEP[i] == 0) lfo = 0;
      else begin
         p   = k % (2 * CDEP[i]);
         lfo = (p <= CDEP[i]) ? p : 2 * CDEP[i] - p;
      end
      cd = CBASE[i] + lfo;
      dc = (n < cd) ? 'h800 : int'(hist[i][n - cd]);
      dr = (n < CRDLY[i]) ? 'h800 : int'(hist[i][n - CRDLY[i]]);
      w  = rv ? (x + dr) / 2 : x;
      y  = ch ? (w + dc) / 2 : w;
      e_caddr[i] = (n - cd) & mask;
      e_raddr[i] = (n - CRDLY[i]) & mask;
      e_waddr[i] = n & mask;
      e_w[i]     = w;
      e_y[i]     = y;
      hist[i][n] = 12'(w);
      cnt[i]     = n + 1;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      sample_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic do_sample(input logic [11:0] x, input bit ch, input bit rv);
      @(negedge clk);
      sample_in = x;
      chorus_on = ch;
      reverb_on = rv;
      sample_valid = 1'b1;
      ob_quiet[0] = 1'b0;
      ob_quiet[1] = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            sample_valid = 1'b0;
            ob_caddr[0] = 32'(addr_a);
            ob_caddr[1] = 32'(addr_b);
         end
         if (c == 2) begin
            ob_raddr[0] = 32'(addr_a);
            ob_raddr[1] = 32'(addr_b);
         end
         if (c == 4) begin
            ob_we[0] = 32'(we_a);       ob_we[1] = 32'(we_b);
            ob_waddr[0] = 32'(addr_a);  ob_waddr[1] = 32'(addr_b);
            ob_wdata[0] = 32'(wdata_a); ob_wdata[1] = 32'(wdata_b);
         end else begin
            if (we_a) ob_quiet[0] = 1'b1;
            if (we_b) ob_quiet[1] = 1'b1;
         end
         if (c == 5) begin
            ob_ovl[0] = 32'(ov_a); ob_ovl[1] = 32'(ov_b);
            ob_out[0] = 32'(out_a); ob_out[1] = 32'(out_b);
         end else begin
            if (ov_a) ob_quiet[0] = 1'b1;
            if (ov_b) ob_quiet[1] = 1'b1;
         end
      end
      ob_orun[0] = 32'(orun_a);
      ob_orun[1] = 32'(orun_b);
      model_step(0, int'(x), ch, rv);
      model_step(1, int'(x), ch, rv);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_total++;
         if ({out_a, ov_a, we_a, orun_a} !== 15'd0)
            $display("FAIL reset_a cyc%0d got out=%h ov=%b we=%b orun=%b want all 0", c, out_a, ov_a, we_a, orun_a);
         else n_pass++;
         n_total++;
         if ({out_b, ov_b, we_b, orun_b} !== 15'd0)
            $display("FAIL reset_b cyc%0d got out=%h ov=%b we=%b orun=%b want all 0", c, out_b, ov_b, we_b, orun_b);
         else n_pass++;
         sample_valid = (c == 0 || c == 2);
      end
      @(negedge clk);
      sample_valid = 1'b0;
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_bypass();
      do_sample(12'h123, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_we[i] !== 1 || ob_waddr[i] !== 0 || ob_wdata[i] !== 32'h0123)
            $display("FAIL bypass_write[%0d] got we=%0d addr=%0d data=%h want 1/0/0123", i, ob_we[i], ob_waddr[i], ob_wdata[i]);
         else n_pass++;
         n_total++;
         if (ob_ovl[i] !== 1 || ob_out[i] !== 32'h123 || ob_quiet[i])
            $display("FAIL bypass_out[%0d] got ov=%0d out=%h stray=%b want 1/123/0", i, ob_ovl[i], ob_out[i], ob_quiet[i]);
         else n_pass++;
      end
      do_sample(12'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_waddr[i] !== 1 || ob_out[i] !== 32'(e_y[i]))
            $display("FAIL bypass_second[%0d] got addr=%0d out=%h want 1/%h", i, ob_waddr[i], ob_out[i], e_y[i]);
         else n_pass++;
      end
   endtask

   task automatic test_chorus_prime();
      do_reset();
      do_sample(12'h000, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_out[i] !== 32'h400) $display("FAIL chorus_prime_lo[%0d] got %h want 400", i, ob_out[i]);
         else n_pass++;
      end
      do_sample(12'hFFF, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_out[i] !== 32'hBFF) $display("FAIL chorus_prime_hi[%0d] got %h want bff", i, ob_out[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reverb();
      logic [11:0] seq [5];
      seq = '{12'hFFF, 12'h800, 12'h800, 12'h800, 12'h800};
      do_reset();
      for (int s = 0; s < 5; s++) begin
         do_sample(seq[s], 1'b0, 1'b1);
         for (int i = 0; i < 2; i++) begin
            n_total++;
            if (ob_out[i] !== 32'(e_y[i]) || ob_wdata[i] !== 32'(e_w[i]))
               $display("FAIL reverb_s%0d[%0d] got out=%h wdata=%h want %h/%h", s, i, ob_out[i], ob_wdata[i], e_y[i], e_w[i]);
            else n_pass++;
         end
         if (s == 0) begin
            n_total++;
            if (ob_out[0] !== 32'hBFF) $display("FAIL reverb_first got %h want bff", ob_out[0]);
            else n_pass++;
         end
      end
      n_total++;
      if (ob_out[0] !== 32'h9FF || ob_raddr[0] !== 0)
         $display("FAIL reverb_fifth got out=%h raddr=%0d want 9ff/0", ob_out[0], ob_raddr[0]);
      else n_pass++;
   endtask

   task automatic test_lfo_wrap();
      int offs [6];
      int got;
      offs = '{1, 2, 3, 2, 1, 2};
      do_reset();
      for (int s = 0; s < 36; s++) begin
         do_sample(12'($urandom), 1'b1, 1'($urandom));
         if (s < 6) begin
            got = int'((ob_waddr[0] - ob_caddr[0]) & 32'hF);
            n_total++;
            if (got !== offs[s]) $display("FAIL lfo_offset s%0d got %0d want %0d", s, got, offs[s]);
            else n_pass++;
         end
         for (int i = 0; i < 2; i++) begin
            n_total++;
            if (ob_caddr[i] !== 32'(e_caddr[i]) || ob_waddr[i] !== 32'(e_waddr[i]) || ob_out[i] !== 32'(e_y[i]))
               $display("FAIL lfo_wrap s%0d[%0d] got c=%0d w=%0d out=%h want %0d/%0d/%h", s, i,
                        ob_caddr[i], ob_waddr[i], ob_out[i], e_caddr[i], e_waddr[i], e_y[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int s = 0; s < 60; s++) begin
         do_sample(12'($urandom), 1'($urandom), 1'($urandom));
         for (int i = 0; i < 2; i++) begin
            n_total++;
            if (ob_caddr[i] !== 32'(e_caddr[i]) || ob_raddr[i] !== 32'(e_raddr[i]))
               $display("FAIL rand_taps s%0d[%0d] got %0d/%0d want %0d/%0d", s, i, ob_caddr[i], ob_raddr[i], e_caddr[i], e_raddr[i]);
            else n_pass++;
            n_total++;
            if (ob_we[i] !== 1 || ob_waddr[i] !== 32'(e_waddr[i]) || ob_wdata[i] !== 32'(e_w[i]))
               $display("FAIL rand_write s%0d[%0d] got we=%0d a=%0d d=%h want 1/%0d/%h", s, i, ob_we[i], ob_waddr[i], ob_wdata[i], e_waddr[i], e_w[i]);
            else n_pass++;
            n_total++;
            if (ob_ovl[i] !== 1 || ob_out[i] !== 32'(e_y[i]) || ob_quiet[i] || ob_orun[i] !== 0)
               $display("FAIL rand_out s%0d[%0d] got ov=%0d out=%h stray=%b orun=%0d want 1/%h/0/0", s, i, ob_ovl[i], ob_out[i], ob_quiet[i], ob_orun[i], e_y[i]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_overrun();
      int pulses [2];
      logic [11:0] got [2];
      logic [11:0] x1;
      x1 = 12'($urandom);
      do_reset();
      pulses = '{0, 0};
      got = '{12'h0, 12'h0};
      @(negedge clk);
      sample_in = x1; chorus_on = 1'b0; reverb_on = 1'b0; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      sample_in = ~x1; sample_valid = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         sample_valid = 1'b0;
         if (ov_a) begin pulses[0]++; got[0] = out_a; end
         if (ov_b) begin pulses[1]++; got[1] = out_b; end
      end
      model_step(0, int'(x1), 1'b0, 1'b0);
      model_step(1, int'(x1), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (pulses[i] !== 1 || got[i] !== 12'(e_y[i]))
            $display("FAIL overrun_single[%0d] got pulses=%0d out=%h want 1/%h", i, pulses[i], got[i], e_y[i]);
         else n_pass++;
      end
      n_total++;
      if (orun_a !== 1'b1 || orun_b !== 1'b1) $display("FAIL overrun_flag got %b%b want 11", orun_a, orun_b);
      else n_pass++;
      do_sample(12'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_orun[i] !== 1 || ob_waddr[i] !== 1 || ob_out[i] !== 32'(e_y[i]))
            $display("FAIL overrun_sticky[%0d] got orun=%0d addr=%0d out=%h want 1/1/%h", i, ob_orun[i], ob_waddr[i], ob_out[i], e_y[i]);
         else n_pass++;
      end
      do_reset();
      n_total++;
      if (orun_a !== 1'b0 || orun_b !== 1'b0) $display("FAIL overrun_clear got %b%b want 00", orun_a, orun_b);
      else n_pass++;
   endtask

   task automatic test_reset_abort();
      do_sample(12'h111, 1'b0, 1'b0);
      @(negedge clk);
      sample_in = 12'h222; sample_valid = 1'b1;
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         reset = 1'b1;
         n_total++;
         if (we_a || we_b || ov_a || ov_b)
            $display("FAIL abort_quiet cyc%0d got we=%b%b ov=%b%b want 0000", c, we_a, we_b, ov_a, ov_b);
         else n_pass++;
      end
      model_reset();
      do_sample(12'h456, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (ob_waddr[i] !== 0 || ob_out[i] !== 32'(e_y[i]))
            $display("FAIL abort_restart[%0d] got addr=%0d out=%h want 0/%h", i, ob_waddr[i], ob_out[i], e_y[i]);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      reset = 1'b0;
      sample_valid = 1'b0;
      sample_in = 12'h000;
      chorus_on = 1'b0;
      reverb_on = 1'b0;
      model_reset();
      test_reset();
      test_bypass();
      test_chorus_prime();
      test_reverb();
      test_lfo_wrap();
      test_random();
      test_overrun();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
